// File: rtl/resp_cap_pkg.sv
// Shared types, default constants and MISR next-state math for the response capture block.
package resp_cap_pkg;

  localparam int unsigned RESP_W = 32;
  localparam int unsigned IDX_W  = $clog2(RESP_W);

  localparam logic [RESP_W-1:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [RESP_W-1:0] DEF_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  // Widths below RESP_W are handled by masking; the top bit of the active width drives feedback.
  function automatic logic [RESP_W-1:0] misr_next(input logic [RESP_W-1:0] sig,
                                                  input logic [RESP_W-1:0] data,
                                                  input logic [RESP_W-1:0] poly,
                                                  input int unsigned w = RESP_W);
    logic [RESP_W-1:0] mask;
    logic [RESP_W-1:0] shifted;
    logic              msb;
    mask    = (w >= RESP_W) ? '1 : ((RESP_W'(1) << w) - RESP_W'(1));
    msb     = sig[IDX_W'(w - 1)];
    shifted = ((sig << 1) & mask) ^ (msb ? poly : '0);
    return (shifted ^ data) & mask;
  endfunction

endpackage

// File: rtl/resp_misr_capture_if.sv
// Response-vector handshake between the circuit-under-test and the capture block.
interface resp_misr_capture_if #(
  parameter int unsigned WIDTH = resp_cap_pkg::RESP_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/misr_core.sv
// Multiple-input signature register: loads the seed on request, compacts one vector per step.
module misr_core
  import resp_cap_pkg::*;
#(
  parameter int unsigned      WIDTH = RESP_W,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [RESP_W-1:0] nxt;

  assign nxt = misr_next(RESP_W'(sig), RESP_W'(data), RESP_W'(POLY), WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= nxt[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/resp_misr_capture.sv
// Compacts a counted stream of response vectors into a MISR and checks it against a golden value.
module resp_misr_capture
  import resp_cap_pkg::*;
#(
  parameter int unsigned      WIDTH = RESP_W,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0],
  parameter int unsigned      CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic [WIDTH-1:0]    golden,
  resp_misr_capture_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [WIDTH-1:0]    signature,
  output logic [CNT_W-1:0]    vec_count
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic xfer;
  logic launch;
  logic last;

  assign xfer   = bus.in_valid & in_ready_q & ~abort;
  assign launch = start & ~abort & ((state_q == StIdle) | (state_q == StDone));
  assign last   = (cnt_q == num_q - CNT_W'(1));

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .step (xfer),
    .data (bus.in_data),
    .sig  (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      num_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else if (abort) begin
      // Signature and count are left untouched for post-mortem inspection.
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            if (num_vec != '0) begin
              num_q      <= num_vec;
              in_ready_q <= 1'b1;
              state_q    <= StRun;
            end else begin
              in_ready_q <= 1'b0;
              state_q    <= StCheck;
            end
          end
        end
        StRun: begin
          if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              in_ready_q <= 1'b0;
              state_q    <= StCheck;
            end
          end
        end
        StCheck: begin
          pass_q  <= (signature == golden);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign vec_count    = cnt_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// Directed bench: expected run results go into a scoreboard queue, a monitor checks each done pulse.
module tb_resp_misr_capture;
  import resp_cap_pkg::*;

  typedef struct packed {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_vec;
  logic [31:0] golden;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [15:0] vec_count;

  int   errors;
  int   checks;
  exp_t sb[$];
  logic done_prev;

  resp_misr_capture_if #(.WIDTH(32)) bus ();

  resp_misr_capture dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .golden    (golden),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] n, input logic [31:0] gold);
    num_vec = n;
    golden  = gold;
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds in_valid until a handshake completes on a clock edge.
  task automatic send(input logic [31:0] d);
    logic rdy;
    bit   ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_0000;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake expected handshake for %h", d);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1");
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = sb.pop_front();
        chk("sb_signature", signature, e.sig);
        chk("sb_pass", 32'(pass), 32'(e.pass));
        chk("sb_vec_count", 32'(vec_count), 32'(e.cnt));
      end
    end
    done_prev <= done;
  end

  initial begin
    logic [31:0] vecs [3];
    logic [31:0] exp_sig;
    int          sent;
    logic        rdy;
    logic        v;

    errors       = 0;
    checks       = 0;
    done_prev    = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    num_vec      = '0;
    golden       = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    vecs[0]      = 32'h12345678;
    vecs[1]      = 32'hDEADBEEF;
    vecs[2]      = 32'h0F0F0F0F;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_signature", signature, 32'hFFFFFFFF);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    tick();

    // Single zero vector with exact done latency.
    sb.push_back('{sig: 32'hFB3EE249, pass: 1'b1, cnt: 16'd1});
    launch(16'd1, 32'hFB3EE249);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    send(32'h0);
    chk("check_done_low", 32'(done), 32'd0);
    chk("check_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    chk("done_latency", 32'(done), 32'd1);
    chk("done_busy_low", 32'(busy), 32'd0);

    // Two vectors, matching then mismatching golden; relaunch from DONE.
    sb.push_back('{sig: 32'hF2BCD924, pass: 1'b1, cnt: 16'd2});
    launch(16'd2, 32'hF2BCD924);
    chk("relaunch_done_clear", 32'(done), 32'd0);
    send(32'h0);
    send(32'h1);
    wait_done();
    tick();
    sb.push_back('{sig: 32'hF2BCD924, pass: 1'b0, cnt: 16'd2});
    launch(16'd2, 32'hF2BCD925);
    chk("relaunch_pass_clear", 32'(pass), 32'd0);
    send(32'h0);
    send(32'h1);
    wait_done();
    tick();

    // Empty runs go straight to CHECK without offering in_ready.
    sb.push_back('{sig: 32'hFFFFFFFF, pass: 1'b1, cnt: 16'd0});
    launch(16'd0, 32'hFFFFFFFF);
    chk("empty_in_ready", 32'(bus.in_ready), 32'd0);
    wait_done();
    tick();
    sb.push_back('{sig: 32'hFFFFFFFF, pass: 1'b0, cnt: 16'd0});
    launch(16'd0, 32'h0);
    chk("empty2_in_ready", 32'(bus.in_ready), 32'd0);
    wait_done();
    tick();

    // Gappy valid with garbage data between beats.
    exp_sig = DEF_SEED;
    for (int i = 0; i < 3; i++) exp_sig = misr_next(exp_sig, vecs[i], DEF_POLY);
    sb.push_back('{sig: exp_sig, pass: (exp_sig == 32'h0), cnt: 16'd3});
    launch(16'd3, 32'h0);
    sent = 0;
    for (int c = 0; c < 80 && sent < 3; c++) begin
      v = 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = v ? vecs[sent] : $urandom;
      rdy = bus.in_ready;
      tick();
      if (v && rdy) sent++;
    end
    bus.in_valid = 1'b0;
    chk("gap_sent", 32'(sent), 32'd3);
    chk("gap_in_ready_drop", 32'(bus.in_ready), 32'd0);
    wait_done();
    tick();

    // Abort after two beats while a third is offered.
    exp_sig = misr_next(misr_next(DEF_SEED, vecs[0], DEF_POLY), vecs[1], DEF_POLY);
    launch(16'd5, 32'h0);
    send(vecs[0]);
    send(vecs[1]);
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[2];
    abort        = 1'b1;
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_vec_count", 32'(vec_count), 32'd2);
    chk("abort_signature", signature, exp_sig);
    sb.push_back('{sig: 32'hFB3EE249, pass: 1'b1, cnt: 16'd1});
    launch(16'd1, 32'hFB3EE249);
    send(32'h0);
    wait_done();
    tick();

    // Asynchronous reset between edges mid-run.
    launch(16'd3, 32'h0);
    send(vecs[0]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_signature", signature, 32'hFFFFFFFF);
    chk("arst_vec_count", 32'(vec_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // start and abort together: abort wins.
    num_vec = 16'd1;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_in_ready", 32'(bus.in_ready), 32'd0);

    sb.push_back('{sig: 32'hF2BCD924, pass: 1'b1, cnt: 16'd2});
    launch(16'd2, 32'hF2BCD924);
    send(32'h0);
    send(32'h1);
    wait_done();
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
